ntt_core_psi_out_unpack: RTL and testbench

// - Output side of the NTT core. Takes the PSI*R coefficients the core emits per cycle and buffers them.
// - Re-serializes them to a narrower OUT_COEF-wide valid/ready stream for the next consumer.
// - The core has no backpressure, so the block buffers internally and raises an early stall hint.
// - It sits between the last NTT stage and the post-NTT accumulation/writeback path.

---
 rtl/ntt_core_psi_unpack_pkg.sv | 32 +++
 rtl/ntt_core_psi_unpack_fifo.sv | 52 +++++
 rtl/ntt_core_psi_out_unpack.sv | 120 ++++++++++++
 tb/tb_ntt_core_psi_out_unpack.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_core_psi_unpack_pkg.sv
// ntt_core_psi_unpack_pkg
// Shared types and sizing for the NTT core output unpacker.
//   CHUNK_NB : number of OUT_COEF-wide chunks per PSI*R-coef input beat
//   CHUNK_W  : width of the chunk counter (at least 1 bit)
//   PTR_W    : FIFO pointer width, log2(DEPTH)
//   CNT_W    : FIFO occupancy width, holds 0..DEPTH
//   coef_t   : one coefficient
//   beat_t   : one FIFO entry {data, last}; data[i] is coefficient i
package ntt_core_psi_unpack_pkg;

  localparam int OP_W      = 64;
  localparam int PSI       = 4;
  localparam int R         = 2;
  localparam int OUT_COEF  = 2;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;

  localparam int BEAT_COEF = PSI * R;
  localparam int CHUNK_NB  = BEAT_COEF / OUT_COEF;
  localparam int CHUNK_W   = (CHUNK_NB > 1) ? $clog2(CHUNK_NB) : 1;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [OP_W-1:0] coef_t;

  // Packed so that data[i] sits at bits [i*OP_W +: OP_W] of the flat bus.
  typedef struct packed {
    coef_t [BEAT_COEF-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/ntt_core_psi_unpack_fifo.sv
// ntt_core_psi_unpack_fifo
// DEPTH-entry register FIFO of beat_t. The head is read straight out of the
// storage registers, so a beat written at cycle t is visible at t+1.
// Ports:
//   clk, s_rst : clock, synchronous active-high reset (clears pointers/count)
//   push       : write wr_beat; caller guarantees !full or a same-cycle pop
//   pop        : retire head; caller guarantees !empty
//   wr_beat    : entry to store
//   head       : oldest entry (undefined content when empty)
//   count      : occupancy 0..DEPTH
//   full/empty : decoded from count
module ntt_core_psi_unpack_fifo
  import ntt_core_psi_unpack_pkg::*;
(
  input  logic             clk,
  input  logic             s_rst,
  input  logic             push,
  input  logic             pop,
  input  beat_t            wr_beat,
  output beat_t            head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; the top gates the outputs while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ntt_core_psi_out_unpack.sv
// ntt_core_psi_out_unpack
// Buffers PSI*R-coefficient beats from the NTT core (no backpressure) and
// re-serializes them as OUT_COEF-wide chunks on a valid/ready stream.
// Ports:
//   clk, s_rst   : clock, synchronous active-high reset
//   in_data      : PSI*R coefs, coef i at [i*OP_W +: OP_W]
//   in_avail     : beat valid, always accepted unless the FIFO is full
//   in_last      : beat is the last of the polynomial
//   in_stall     : registered almost-full hint (next count >= DEPTH-AF_MARGIN)
//   out_data     : chunk, chunk 0 carries the lowest-index coefs
//   out_vld      : chunk valid
//   out_rdy      : consumer ready
//   out_last     : final chunk of a beat flagged last
//   out_ovf      : sticky overflow flag
// Handshake: a chunk transfers on a cycle where out_vld & out_rdy are both 1;
// while out_vld=1 and out_rdy=0, out_data/out_last hold and out_vld stays high.
// out_vld, out_data and out_last depend only on registers, never on out_rdy.
// Configuration macro NTT_CORE_PSI_UNPACK_OVF_EN: when defined, out_ovf is
// a sticky flag set by a dropped beat (cleared by s_rst) and a simulation
// assertion reports the drop; when undefined, out_ovf is tied to 0.
module ntt_core_psi_out_unpack
  import ntt_core_psi_unpack_pkg::*;
(
  input  logic                      clk,
  input  logic                      s_rst,
  input  logic [BEAT_COEF*OP_W-1:0] in_data,
  input  logic                      in_avail,
  input  logic                      in_last,
  output logic                      in_stall,
  output logic [OUT_COEF*OP_W-1:0]  out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      out_last,
  output logic                      out_ovf
);

  if ((BEAT_COEF % OUT_COEF) != 0) begin : g_bad_chunk
    $fatal(1, "PSI*R must be a multiple of OUT_COEF");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two and at least 4");
  end

  beat_t              wr_beat;
  beat_t              head;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               full;
  logic               empty;
  logic [CHUNK_W-1:0] chk;
  logic               last_chk;
  logic               xfer;
  logic               pop;
  logic               push;

  assign wr_beat  = {in_data, in_last};
  assign last_chk = (chk == CHUNK_W'(CHUNK_NB - 1));
  assign xfer     = out_vld & out_rdy;
  assign pop      = xfer & last_chk;
  // A beat arriving while full is accepted only if the head retires this cycle.
  assign push     = in_avail & (~full | pop);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  ntt_core_psi_unpack_fifo u_fifo (
    .clk     (clk),
    .s_rst   (s_rst),
    .push    (push),
    .pop     (pop),
    .wr_beat (wr_beat),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (s_rst) begin
      chk      <= '0;
      in_stall <= 1'b0;
    end else begin
      if (xfer) chk <= last_chk ? '0 : chk + CHUNK_W'(1);
      in_stall <= (count_nxt >= CNT_W'(DEPTH - AF_MARGIN));
    end
  end

  assign out_vld  = ~empty;
  assign out_last = out_vld & head.last & last_chk;

  always_comb begin
    out_data = '0;
    if (out_vld) begin
      for (int j = 0; j < OUT_COEF; j++) begin
        out_data[j*OP_W +: OP_W] = head.data[int'(chk) * OUT_COEF + j];
      end
    end
  end

`ifdef NTT_CORE_PSI_UNPACK_OVF_EN
  logic overflow;
  logic ovf_q;

  assign overflow = in_avail & full & ~pop;

  always_ff @(posedge clk) begin
    if (s_rst)         ovf_q <= 1'b0;
    else if (overflow) ovf_q <= 1'b1;
  end

  assign out_ovf = ovf_q;

  always @(posedge clk) begin
    if (!s_rst) begin
      assert (!overflow) else $warning("ntt_core_psi_out_unpack: beat dropped, FIFO full");
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_core_psi_out_unpack.sv
// Bench for ntt_core_psi_out_unpack. The reference keeps a queue of whole
// beats plus a chunk index; the scoreboard holds the expected chunk stream.
module tb_ntt_core_psi_out_unpack;
  import ntt_core_psi_unpack_pkg::*;

  localparam int BW = BEAT_COEF * OP_W;
  localparam int CW = OUT_COEF * OP_W;
  localparam int AF = DEPTH - AF_MARGIN;

  typedef struct packed {
    logic [BW-1:0] d;
    logic          l;
  } tb_beat_t;

  // clock / reset
  logic          clk = 1'b0;
  logic          s_rst = 1'b1;
  logic [BW-1:0] in_data = '0;
  logic          in_avail = 1'b0;
  logic          in_last = 1'b0;
  logic          in_stall;
  logic [CW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic          out_last;
  logic          out_ovf;

  always #5 clk = ~clk;

  ntt_core_psi_out_unpack dut (
    .clk      (clk),
    .s_rst    (s_rst),
    .in_data  (in_data),
    .in_avail (in_avail),
    .in_last  (in_last),
    .in_stall (in_stall),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last),
    .out_ovf  (out_ovf)
  );

  // reference model + scoreboard
  tb_beat_t      beat_q[$];
  logic [CW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            chk_m;
  logic          ovf_m;
  int            tests_run;
  int            tests_failed;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_state(input string tag);
    logic [CW-1:0] hd;
    logic          hl;
    hd = '0;
    hl = 1'b0;
    if (beat_q.size() > 0) begin
      hd = beat_q[0].d[chk_m*CW +: CW];
      hl = beat_q[0].l && (chk_m == CHUNK_NB - 1);
    end
    check({tag, "_vld"},   out_vld,  beat_q.size() > 0);
    check({tag, "_data"},  out_data, hd);
    check({tag, "_last"},  out_last, hl);
    check({tag, "_stall"}, in_stall, beat_q.size() >= AF);
    check({tag, "_ovf"},   out_ovf,  ovf_m);
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input logic av, input logic [BW-1:0] data_in, input logic lst, input logic rdy);
    logic     xfer_m;
    logic     pop_m;
    tb_beat_t nb;
    in_avail = av;
    in_data  = data_in;
    in_last  = lst;
    out_rdy  = rdy;
    xfer_m = (beat_q.size() > 0) && rdy;
    pop_m  = xfer_m && (chk_m == CHUNK_NB - 1);
    if (xfer_m) begin
      check("xfer_data", out_data, exp_q.pop_front());
      check("xfer_last", out_last, exp_last_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (xfer_m) begin
      if (pop_m) begin
        chk_m = 0;
        beat_q.delete(0);
      end else begin
        chk_m++;
      end
    end
    if (av) begin
      if (beat_q.size() < DEPTH) begin
        nb.d = data_in;
        nb.l = lst;
        beat_q.push_back(nb);
        for (int c = 0; c < CHUNK_NB; c++) begin
          exp_q.push_back(data_in[c*CW +: CW]);
          exp_last_q.push_back(lst && (c == CHUNK_NB - 1));
        end
      end else begin
`ifdef NTT_CORE_PSI_UNPACK_OVF_EN
        ovf_m = 1'b1;
`endif
      end
    end
    in_avail = 1'b0;
    check_state("cyc");
  endtask

  task automatic do_reset();
    s_rst    = 1'b1;
    in_avail = 1'b0;
    out_rdy  = 1'b0;
    @(posedge clk);
    #1;
    s_rst = 1'b0;
    beat_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    chk_m = 0;
    ovf_m = 1'b0;
    check_state("rst");
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("drained_vld", out_vld, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] ramp;
    tests_run    = 0;
    tests_failed = 0;
    chk_m        = 0;
    ovf_m        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single beat, coefs 0..7, consumer always ready
    for (int i = 0; i < BEAT_COEF; i++) ramp[i*OP_W +: OP_W] = OP_W'(i);
    step(1'b1, ramp, 1'b1, 1'b1);
    check("ramp_chunk0", out_data, {64'd1, 64'd0});
    drain(6);

    // consumer stalls 10 cycles mid-stream
    step(1'b1, rand_beat(), 1'b0, 1'b1);
    step(1'b1, rand_beat(), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
    drain(10);

    // 6 beats with no consumer: stall hint, then drain
    for (int i = 0; i < 6; i++) step(1'b1, rand_beat(), 1'(i == 5), 1'b0);
    check("six_stall", in_stall, 1'b1);
    drain(26);

    // 9 beats into an 8-deep FIFO: the ninth is dropped
    for (int i = 0; i < 9; i++) step(1'b1, rand_beat(), 1'(i == 8), 1'b0);
    drain(34);
    do_reset();

    // push together with the final-chunk pop while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_beat(), 1'b0, 1'b0);
    for (int i = 0; i < CHUNK_NB - 1; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, rand_beat(), 1'b1, 1'b1);
    check("full_swap_ovf", out_ovf, 1'b0);
    drain(34);

    // reset with 3 beats stored, then a fresh beat
    for (int i = 0; i < 3; i++) step(1'b1, rand_beat(), 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, ramp, 1'b1, 1'b1);
    check("fresh_chunk0", out_data, {64'd1, 64'd0});
    drain(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 5) == 0), rand_beat(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end
    drain(40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
